crc_check: RTL

CRC_CHECK -- requirements
Module: crc_check

---
 rtl/crc_check_if.sv | 42 ++++
 rtl/crc_check.sv | 136 +++++++++++++
 2 files changed

// File: rtl/crc_check_if.sv
// rtl/crc_check_if.sv - dibit stream and frame-status signals of the CRC checker
//
// Purpose: bundles the received dibit stream (d/sop/eop), the stripped payload
// stream (d_out/vld_out/sop_out/eop_out) and the per-frame status strobe
// (done/crc_ok/runt) so the checker and its source/sink connect as one port.
//
// Signals:
//   d[1:0]      received dibit, d[0] is the earlier bit in time
//   sop, eop    first / last dibit of an input frame (last dibit is FCS)
//   d_out[1:0]  payload dibit with the FCS removed
//   vld_out     d_out carries a payload dibit
//   sop_out     first payload dibit of a frame
//   eop_out     last payload dibit of a frame
//   done        one-cycle frame status strobe
//   crc_ok      FCS good (valid with done)
//   runt        frame shorter than 17 dibits (valid with done)
//
// Modports: master drives the input stream and observes results;
//           slave is the checker itself.

interface crc_check_if;
  logic [1:0] d;
  logic       sop;
  logic       eop;
  logic [1:0] d_out;
  logic       vld_out;
  logic       sop_out;
  logic       eop_out;
  logic       done;
  logic       crc_ok;
  logic       runt;

  modport master (
    output d, sop, eop,
    input  d_out, vld_out, sop_out, eop_out, done, crc_ok, runt
  );

  modport slave (
    input  d, sop, eop,
    output d_out, vld_out, sop_out, eop_out, done, crc_ok, runt
  );
endinterface

// File: rtl/crc_check.sv
// rtl/crc_check.sv - dibit-serial CRC-32 frame checker with FCS stripping
//
// Purpose: absorbs every dibit of a frame (sop..eop, FCS included) into a
// 32-bit MSB-first LFSR, delays the stream by 16 dibits so the trailing FCS
// never leaves the block, and reports one status strobe per frame.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   crc_check_if.slave: d/sop/eop in; d_out/vld_out/sop_out/eop_out,
//         done/crc_ok/runt out (all outputs registered)
//
// Parameters:
//   N        CRC width (32 only)
//   POLY     generator polynomial, normal form
//   RESIDUE  register value of a good frame after the FCS is absorbed

module crc_check #(
  parameter int             N       = 32,
  parameter logic [N-1:0]   POLY    = 32'h04C11DB7,
  parameter logic [N-1:0]   RESIDUE = 32'hC704DD7B
) (
  input  logic        clk,
  input  logic        rst,
  crc_check_if.slave  bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t       state, state_nx;
  logic [N-1:0] crc, crc_base, crc_mid, crc_nx;
  logic [4:0]   cnt, held, cnt_nx;
  logic [1:0]   dl [0:15];

  logic         in_frame;
  logic         abort;
  logic         fin;
  logic         fwd;

  logic [1:0]   d_out_nx;
  logic         vld_nx, sop_out_nx, eop_out_nx;
  logic         done_nx, crc_ok_nx, runt_nx;

  // One serial MSB-first LFSR step.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] c, input logic b);
    lfsr_step = {c[N-2:0], 1'b0} ^ ((b ^ c[N-1]) ? POLY : '0);
  endfunction

  always_comb begin
    state_nx   = state;
    in_frame   = bus.sop || (state == RECV);
    // sop restarts counting, so the sop dibit itself sees an empty delay line
    held       = bus.sop ? 5'd0 : cnt;
    cnt_nx     = cnt;
    crc_base   = bus.sop ? '1 : crc;
    crc_mid    = lfsr_step(crc_base, bus.d[0]);
    crc_nx     = lfsr_step(crc_mid, bus.d[1]);
    abort      = bus.sop && (state == RECV);
    fin        = in_frame && bus.eop && !abort;
    fwd        = in_frame && (held >= 5'd16);

    d_out_nx   = 2'b00;
    vld_nx     = 1'b0;
    sop_out_nx = 1'b0;
    eop_out_nx = 1'b0;
    done_nx    = 1'b0;
    crc_ok_nx  = 1'b0;
    runt_nx    = 1'b0;

    if (bus.sop) begin
      state_nx = bus.eop ? IDLE : RECV;
    end else if ((state == RECV) && bus.eop) begin
      state_nx = IDLE;
    end

    if (in_frame) begin
      cnt_nx = (held == 5'd17) ? 5'd17 : held + 5'd1;
    end

    // The oldest held dibit is payload whenever 16 newer dibits follow it,
    // which is why the trailing 16 FCS dibits are never forwarded.
    if (fwd) begin
      vld_nx     = 1'b1;
      d_out_nx   = dl[15];
      sop_out_nx = (held == 5'd16);
      eop_out_nx = bus.eop;
    end

    if (abort) begin
      done_nx = 1'b1;
    end else if (fin) begin
      done_nx   = 1'b1;
      runt_nx   = (held < 5'd16);
      crc_ok_nx = (held >= 5'd16) && (crc_nx == RESIDUE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      crc         <= '1;
      bus.d_out   <= 2'b00;
      bus.vld_out <= 1'b0;
      bus.sop_out <= 1'b0;
      bus.eop_out <= 1'b0;
      bus.done    <= 1'b0;
      bus.crc_ok  <= 1'b0;
      bus.runt    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      if (in_frame) begin
        crc <= crc_nx;
      end
      bus.d_out   <= d_out_nx;
      bus.vld_out <= vld_nx;
      bus.sop_out <= sop_out_nx;
      bus.eop_out <= eop_out_nx;
      bus.done    <= done_nx;
      bus.crc_ok  <= crc_ok_nx;
      bus.runt    <= runt_nx;
    end
  end

  // Delay line is not reset: the counter gates forwarding until it is refilled.
  always_ff @(posedge clk) begin
    if (in_frame) begin
      for (int i = 15; i > 0; i--) begin
        dl[i] <= dl[i-1];
      end
      dl[0] <= bus.d;
    end
  end

endmodule
